// File: rtl/reg_pair_ctrl.sv
// Purpose: byte/pair register access controller sequencing a single-port 8-bit register file for 8/16-bit reads, writes, INC16/DEC16.
// Latency: accept to response valid RD8 3, WR8 2, RD16 4, WR16 3, INC16/DEC16 6, illegal 1 cycles.
// Backpressure: one command in flight; o_cmd_ready only in IDLE, response held stable until i_rsp_ready.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_ready       command channel (op, 8-bit reg, pair, 16-bit data)
//   o_rsp_*/i_rsp_ready       response channel (16-bit data, illegal-op error)
//   o_rf_*/i_rf_rdata         register-file strobes; read data returns the cycle after o_rf_rd_en
module reg_pair_ctrl #(
    parameter logic [7:0] F_MASK        = 8'hF0,
    parameter int         RF_ADDR_WIDTH = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [2:0]               i_cmd_op,
    input  logic [2:0]               i_cmd_reg,
    input  logic [1:0]               i_cmd_pair,
    input  logic [15:0]              i_cmd_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [15:0]              o_rsp_data,
    output logic                     o_rsp_err,
    output logic                     o_rf_rd_en,
    output logic                     o_rf_wr_en,
    output logic [RF_ADDR_WIDTH-1:0] o_rf_addr,
    output logic [7:0]               o_rf_wdata,
    input  logic [7:0]               i_rf_rdata
);

    localparam logic [2:0] OP_RD8  = 3'b000;
    localparam logic [2:0] OP_WR8  = 3'b001;
    localparam logic [2:0] OP_RD16 = 3'b010;
    localparam logic [2:0] OP_WR16 = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;

    localparam logic [2:0] ADDR_F  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI,
        S_RD_LO,
        S_CAP,
        S_WR_LO,
        S_WR_HI,
        S_RSP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Held low through reset and for the first edge after release so that
    // o_cmd_ready only rises once the block is actually clocking.
    logic        live;

    logic [2:0]  op_q;
    logic [2:0]  reg_q;
    logic [1:0]  pair_q;
    logic [15:0] val_q;
    logic        err_q;

    logic        accept;
    logic        is8;
    logic [2:0]  hi_addr;
    logic [2:0]  pair_lo;
    logic [2:0]  lo_addr;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_raw;
    logic [7:0]  wr_byte;

    assign accept = (state == S_IDLE) && live && i_cmd_valid;
    assign is8    = (op_q == OP_RD8) || (op_q == OP_WR8);

    // AF is the odd pair: A (7) is the high byte, F (6) the low byte.
    always_comb begin
        hi_addr = {pair_q, 1'b0};
        pair_lo = {pair_q, 1'b1};
        if (pair_q == 2'd3) begin
            hi_addr = 3'd7;
            pair_lo = 3'd6;
        end
    end

    assign lo_addr = is8 ? reg_q : pair_lo;
    assign wr_addr = (state == S_WR_HI) ? hi_addr : lo_addr;
    assign wr_raw  = (state == S_WR_HI) ? val_q[15:8] : val_q[7:0];
    assign wr_byte = (wr_addr == ADDR_F) ? (wr_raw & F_MASK) : wr_raw;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (i_cmd_op)
                        OP_RD8:                  state_nxt = S_RD_LO;
                        OP_WR8, OP_WR16:         state_nxt = S_WR_LO;
                        OP_RD16, OP_INC, OP_DEC: state_nxt = S_RD_HI;
                        default:                 state_nxt = S_RSP;
                    endcase
                end
            end
            S_RD_HI: state_nxt = S_RD_LO;
            S_RD_LO: state_nxt = S_CAP;
            S_CAP:   state_nxt = ((op_q == OP_INC) || (op_q == OP_DEC)) ? S_WR_LO : S_RSP;
            S_WR_LO: state_nxt = (op_q == OP_WR8) ? S_RSP : S_WR_HI;
            S_WR_HI: state_nxt = S_RSP;
            S_RSP:   state_nxt = i_rsp_ready ? S_IDLE : S_RSP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: everything decodes from state so reset clears it at once.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_data  = 16'h0000;
        o_rsp_err   = 1'b0;
        o_rf_rd_en  = 1'b0;
        o_rf_wr_en  = 1'b0;
        o_rf_addr   = '0;
        o_rf_wdata  = 8'h00;
        case (state)
            S_IDLE: o_cmd_ready = live;
            S_RD_HI: begin
                o_rf_rd_en = 1'b1;
                o_rf_addr  = hi_addr;
            end
            S_RD_LO: begin
                o_rf_rd_en = 1'b1;
                o_rf_addr  = lo_addr;
            end
            S_WR_LO, S_WR_HI: begin
                o_rf_wr_en = 1'b1;
                o_rf_addr  = wr_addr;
                o_rf_wdata = wr_byte;
            end
            S_RSP: begin
                o_rsp_valid = 1'b1;
                o_rsp_data  = val_q;
                o_rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Datapath: val_q carries write data in, read data back, and the masked
    // bytes actually written so the response reflects register contents.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_q   <= 3'b000;
            reg_q  <= 3'b000;
            pair_q <= 2'b00;
            val_q  <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= i_cmd_op;
                        reg_q  <= i_cmd_reg;
                        pair_q <= i_cmd_pair;
                        err_q  <= (i_cmd_op == 3'b110) || (i_cmd_op == 3'b111);
                        case (i_cmd_op)
                            OP_WR8:  val_q <= {8'h00, i_cmd_data[7:0]};
                            OP_WR16: val_q <= i_cmd_data;
                            default: val_q <= 16'h0000;
                        endcase
                    end
                end
                // High byte read in RD_HI returns during RD_LO.
                S_RD_LO: begin
                    if (!is8) begin
                        val_q[15:8] <= i_rf_rdata;
                    end
                end
                // Low byte returns during CAP; INC/DEC fold the update in here.
                S_CAP: begin
                    case (op_q)
                        OP_INC:  val_q <= {val_q[15:8], i_rf_rdata} + 16'h0001;
                        OP_DEC:  val_q <= {val_q[15:8], i_rf_rdata} - 16'h0001;
                        default: val_q[7:0] <= i_rf_rdata;
                    endcase
                end
                S_WR_LO: val_q[7:0]  <= wr_byte;
                S_WR_HI: val_q[15:8] <= wr_byte;
                default: ;
            endcase
        end
    end

endmodule
